// File: rtl/hm01b0_sim_pkg.sv
// rtl/hm01b0_sim_pkg.sv - Shared constants, state encoding and LFSR helper for the HM01B0 pattern source
// Contents: mode codes, LFSR tap mask, default geometry, FSM states, lfsr_step().
package hm01b0_sim_pkg;

  localparam logic [1:0] MODE_RAMP    = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_BARS    = 2'd2;
  localparam logic [1:0] MODE_LFSR    = 2'd3;

  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;
  localparam int DEF_HPAD   = 20;
  localparam int DEF_VPAD   = 30;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/hm01b0_pixel_serializer.sv
// rtl/hm01b0_pixel_serializer.sv - Splits an 8-bit pixel into BUS_WIDTH-wide beats, MSB first
// Ports: clk, reset (sync, active-high), run (0 forces idle output), load (take pixel this cycle),
//        pixel[7:0] in; pixdata[BUS_WIDTH-1:0] registered beat out.
module hm01b0_pixel_serializer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 load,
  input  logic [7:0]           pixel,
  output logic [BUS_WIDTH-1:0] pixdata
);

  // Holds the not-yet-emitted bits left-aligned so the next beat is always the top slice.
  logic [7:0] shreg;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      pixdata <= '0;
      shreg   <= '0;
    end else if (load) begin
      pixdata <= pixel[7 -: BUS_WIDTH];
      shreg   <= pixel << BUS_WIDTH;
    end else begin
      pixdata <= shreg[7 -: BUS_WIDTH];
      shreg   <= shreg << BUS_WIDTH;
    end
  end

endmodule

// File: rtl/hm01b0_pattern_sim.sv
// rtl/hm01b0_pattern_sim.sv - Framed test-pattern video source standing in for the HM01B0 sensor
// Ports: mclk, reset (sync, active-high), enable, mode[1:0] in;
//        pclk, pixdata[BUS_WIDTH-1:0], hsync, vsync, frame_done, frame_count[15:0] out.
// Option: HM01B0_SIM_FRAME_STAMP_EN overlays frame_count on pixels (0,0) and (1,0).
module hm01b0_pattern_sim
  import hm01b0_sim_pkg::*;
#(
  parameter int         WIDTH     = DEF_WIDTH,
  parameter int         HEIGHT    = DEF_HEIGHT,
  parameter int         HPAD      = DEF_HPAD,
  parameter int         VPAD      = DEF_VPAD,
  parameter int         BUS_WIDTH = 8,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  output logic                 pclk,
  output logic [BUS_WIDTH-1:0] pixdata,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_done,
  output logic [15:0]          frame_count
);

  if (!(BUS_WIDTH == 8 || BUS_WIDTH == 4 || BUS_WIDTH == 1)) begin : g_bad_bus
    $error("hm01b0_pattern_sim: BUS_WIDTH must be 8, 4 or 1");
  end
  if (SEED == 8'h00) begin : g_bad_seed
    $error("hm01b0_pattern_sim: SEED must be nonzero");
  end

  localparam int          B         = 8 / BUS_WIDTH;
  localparam logic [3:0]  BEAT_LAST = 4'(B - 1);
  localparam logic [15:0] X_LAST    = 16'(WIDTH + HPAD - 1);
  localparam logic [15:0] Y_LAST    = 16'(HEIGHT + VPAD - 1);
  localparam logic [15:0] W_L       = 16'(WIDTH);
  localparam logic [15:0] H_L       = 16'(HEIGHT);
  localparam logic [15:0] BAR_LAST  = 16'((WIDTH / 8 > 1) ? (WIDTH / 8 - 1) : 0);

  assign pclk = mclk;

  state_t      state;
  logic [15:0] x, y;
  logic [3:0]  beat;
  logic [1:0]  mode_q;
  logic [7:0]  lfsr_q;
  logic [2:0]  bar_idx;
  logic [15:0] bar_cnt;

  logic       run, active, beat_last, line_last, frame_start, frame_last;
  logic [1:0] mode_cur;
  logic [7:0] lfsr_cur, pixel;

  assign run         = (state == ST_RUN);
  assign active      = (x < W_L) && (y < H_L);
  assign beat_last   = (beat == BEAT_LAST);
  assign line_last   = (x == X_LAST);
  assign frame_start = run && (x == '0) && (y == '0) && (beat == '0);
  assign frame_last  = run && beat_last && line_last && (y == Y_LAST);

  // The first pixel of a frame must already see the newly latched mode and the reseeded LFSR.
  assign mode_cur = frame_start ? mode : mode_q;
  assign lfsr_cur = frame_start ? SEED : lfsr_q;

  always_comb begin
    pixel = 8'h00;
    case (mode_cur)
      MODE_RAMP:    pixel = x[7:0] + y[7:0];
      MODE_CHECKER: pixel = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      MODE_BARS:    pixel = {bar_idx, 5'b00000};
      MODE_LFSR:    pixel = lfsr_cur;
      default:      pixel = 8'h00;
    endcase
`ifdef HM01B0_SIM_FRAME_STAMP_EN
    if (y == '0 && x == 16'd0) pixel = frame_count[15:8];
    else if (y == '0 && x == 16'd1) pixel = frame_count[7:0];
`endif
    if (!active) pixel = 8'h00;
  end

  hm01b0_pixel_serializer #(.BUS_WIDTH(BUS_WIDTH)) u_ser (
    .clk    (mclk),
    .reset  (reset),
    .run    (run),
    .load   (beat == 4'd0),
    .pixel  (pixel),
    .pixdata(pixdata)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      beat        <= '0;
      mode_q      <= MODE_RAMP;
      lfsr_q      <= SEED;
      bar_idx     <= '0;
      bar_cnt     <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          hsync      <= 1'b0;
          vsync      <= 1'b0;
          frame_done <= 1'b0;
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          hsync      <= active;
          vsync      <= (y < H_L);
          frame_done <= frame_last;
          if (frame_start) mode_q <= mode;
          if (active && beat_last) lfsr_q <= lfsr_step(lfsr_cur);
          else if (frame_start)    lfsr_q <= SEED;
          if (!beat_last) begin
            beat <= beat + 4'd1;
          end else begin
            beat <= '0;
            if (line_last) begin
              x       <= '0;
              bar_cnt <= '0;
              bar_idx <= '0;
              if (y == Y_LAST) begin
                y           <= '0;
                frame_count <= frame_count + 16'd1;
                if (!enable) state <= ST_IDLE;
              end else begin
                y <= y + 16'd1;
              end
            end else begin
              x <= x + 16'd1;
              // Bar index saturates at 7 so the last bar absorbs WIDTH%8 leftover pixels.
              if (bar_cnt == BAR_LAST && bar_idx != 3'd7) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
              end else begin
                bar_cnt <= bar_cnt + 16'd1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
